firstq_sweep: RTL and testbench

Sequential exhaustive-test driver for the four-input `firstQ` switch-level gate. On `start` it sequences inputs a,b,c,d through all 16 combinations, waits a programmable settle time per vector, samples the gate's `out`, and compares it against the expected truth table. It produces the captured table, a mismatch map, and a pass/fail verdict. It sits directly upstream of the gate, driving its inputs, and also consumes its output.

---
 rtl/firstq_pkg.sv | 16 +
 rtl/firstq_sweep_settle_timer.sv | 26 ++
 rtl/firstq_sweep.sv | 111 +++++++++++
 tb/tb_firstq_sweep.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/firstq_pkg.sv
// firstq_pkg: shared types and constants for the firstQ exhaustive sweep driver.
package firstq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int VEC_W = 4;

    // Known-good truth table of the firstQ gate; bit i is out for {a,b,c,d} == i.
    localparam logic [15:0] FIRSTQ_TT = 16'hFE51;

endpackage

// File: rtl/firstq_sweep_settle_timer.sv
// settle_timer: 4-bit loadable down-counter with a zero flag.
// Ports: clk, rst_n (sync, active-low); load/load_val reload the count;
//        en decrements it; zero is high while the count is 0.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count - 4'd1;
    end

    assign zero = count == 4'd0;

endmodule

// File: rtl/firstq_sweep.sv
// firstq_sweep: drives all 16 input vectors into the firstQ gate, samples its output
// after a settle time and compares it with the expected truth table.
// Ports: clk, rst_n (sync, active-low); start requests a sweep (IDLE only);
//        f_in is the gate output; a..d drive the gate (a = vec[3]);
//        busy/done/pass give status; result_table holds the captured outputs,
//        mismatch the failing vectors, fail_count their number and
//        first_fail the lowest failing vector.
module firstq_sweep
    import firstq_pkg::*;
#(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = FIRSTQ_TT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result_table,
    output logic [15:0] mismatch,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail
);

    state_t           state, state_nx;
    logic [VEC_W-1:0] vec;
    logic             t_load, t_en, t_zero;
    logic             last, miss, accept;

    assign last   = &vec;
    assign miss   = f_in ^ EXPECTED[vec];
    assign accept = state == ST_IDLE && start;

    settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .en       (t_en),
        .load_val (4'(SETTLE - 1)),
        .zero     (t_zero)
    );

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        t_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                t_load   = start;
                state_nx = start ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                t_en     = !t_zero;
                state_nx = t_zero ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SAMPLE: begin
                t_load   = !last;
                state_nx = last ? ST_DONE : ST_SETTLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            vec          <= '0;
            pass         <= 1'b0;
            result_table <= '0;
            mismatch     <= '0;
            fail_count   <= '0;
            first_fail   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                vec          <= '0;
                pass         <= 1'b0;
                result_table <= '0;
                mismatch     <= '0;
                fail_count   <= '0;
                first_fail   <= '0;
            end
            if (state == ST_SAMPLE) begin
                result_table[vec] <= f_in;
                mismatch[vec]     <= miss;
                // fail_count still 0 means this is the first failure of the sweep
                if (miss) begin
                    fail_count <= fail_count + 5'd1;
                    if (fail_count == 5'd0)
                        first_fail <= vec;
                end
                // the bit for the last vector is still clear, so fold miss in
                if (last)
                    pass <= ~|mismatch & ~miss;
                else
                    vec <= vec + 4'd1;
            end
        end
    end

    assign {a, b, c, d} = vec;
    assign busy         = state == ST_SETTLE || state == ST_SAMPLE;
    assign done         = state == ST_DONE;

endmodule

// File: tb/tb_firstq_sweep.sv
// tb_firstq_sweep: randomized self-checking bench for firstq_sweep, two instances
// (SETTLE=2 and SETTLE=1) checked every cycle against a timeline model.
module tb_firstq_sweep;

    localparam logic [15:0] EXP = 16'hFE51;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        f_in [2];
    logic        a [2], b [2], c [2], d [2];
    logic        busy [2], done [2], pass [2];
    logic [15:0] tab [2], mis [2];
    logic [4:0]  fc [2];
    logic [3:0]  ff [2];
    logic [3:0]  prev [2];

    int          mode = 0;
    logic [15:0] mask = '0;
    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          ndone [2] = '{0, 0};
    int          k [2] = '{-1, -1};
    logic [15:0] snap [2];
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    firstq_sweep dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .result_table(tab[0]), .mismatch(mis[0]),
        .fail_count(fc[0]), .first_fail(ff[0])
    );

    firstq_sweep #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .result_table(tab[1]), .mismatch(mis[1]),
        .fail_count(fc[1]), .first_fail(ff[1])
    );

    // Gate behaviour per mode: 0 real, 1 stuck-at-0, 2 vector 8 flipped,
    // 3 random fault mask, 4 real but wrong in the cycle after an input change.
    function automatic logic gate(int m, logic [15:0] msk, logic [3:0] v);
        logic t;
        t = EXP[v];
        return m == 1 ? 1'b0 : m == 2 ? t ^ (v == 4'd8) : m == 3 ? t ^ msk[v] : t;
    endfunction

    assign f_in[0] = gate(mode, mask, {a[0], b[0], c[0], d[0]})
                     ^ (mode == 4 && {a[0], b[0], c[0], d[0]} != prev[0]);
    assign f_in[1] = gate(mode, mask, {a[1], b[1], c[1], d[1]})
                     ^ (mode == 4 && {a[1], b[1], c[1], d[1]} != prev[1]);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev[0] <= {a[0], b[0], c[0], d[0]};
        prev[1] <= {a[1], b[1], c[1], d[1]};
    end

    always @(negedge clk) begin
        if (done[0]) ndone[0]++;
        if (done[1]) ndone[1]++;
    end

    function automatic int sv(int j);
        return j == 0 ? 2 : 1;
    endfunction

    function automatic int sweep_len(int j);
        return 16 * (sv(j) + 1);
    endfunction

    function automatic logic idle(int j);
        return k[j] < 0 || k[j] >= sweep_len(j) + 1;
    endfunction

    task automatic chk(string name, int j, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h want=%0h cyc=%0d", name, j, got, want, cyc);
        end
    endtask

    // Model: k counts edges since the accepted start; the gate's correct-at-sample
    // response for every vector is snapshotted at acceptance.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n)
                k[j] = -1;
            else if (idle(j) && start) begin
                k[j] = 0;
                for (int v = 0; v < 16; v++) snap[j][v] = gate(mode, mask, 4'(v));
            end else if (k[j] >= 0 && k[j] < sweep_len(j) + 2)
                k[j]++;
        end
    end

    task automatic check_dut(int j);
        int          s, len, kk;
        logic [15:0] sm, et, em;
        logic [3:0]  ev, ef;
        s   = sv(j);
        len = sweep_len(j);
        kk  = k[j];
        sm  = '0;
        for (int v = 0; v < 16; v++)
            if (kk >= 0 && (s + 1) * (v + 1) <= kk) sm[v] = 1'b1;
        et = snap[j] & sm;
        em = (snap[j] ^ EXP) & sm;
        ev = kk < 0 ? 4'd0 : kk < len ? 4'(kk / (s + 1)) : 4'd15;
        ef = '0;
        for (int v = 15; v >= 0; v--)
            if (em[v]) ef = 4'(v);
        chk("vec", j, {a[j], b[j], c[j], d[j]}, ev);
        chk("busy", j, busy[j], kk >= 0 && kk < len);
        chk("done", j, done[j], kk == len);
        chk("pass", j, pass[j], kk >= len && em == 0);
        chk("table", j, tab[j], et);
        chk("mismatch", j, mis[j], em);
        chk("fail_count", j, fc[j], $countones(em));
        chk("first_fail", j, ff[j], ef);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0);
            check_dut(1);
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go(int m, logic [15:0] msk, output int c0);
        mode  = m;
        mask  = msk;
        start = 1'b1;
        step(1);
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_done(int j, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            if (done[j]) begin
                at = cyc;
                break;
            end
            step(1);
        end
        chk("done_seen", j, at >= 0, 1);
        step(1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && !(idle(0) && idle(1)); i++) step(1);
        chk("idle_reached", 0, idle(0) && idle(1), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0, at, n;
        step(3);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_table", 0, tab[0], 0);
        chk("rst_pass", 0, pass[0], 0);

        go(0, '0, c0);
        wait_done(1, at);
        chk("lat_settle1", 1, at - c0, 32);
        chk("table_settle1", 1, tab[1], 16'hFE51);
        wait_done(0, at);
        chk("lat_real", 0, at - c0, 48);
        chk("table_real", 0, tab[0], 16'hFE51);
        chk("mis_real", 0, mis[0], 16'h0000);
        chk("fc_real", 0, fc[0], 0);
        chk("pass_real", 0, pass[0], 1);
        wait_idle();

        go(1, '0, c0);
        wait_done(0, at);
        chk("table_zero", 0, tab[0], 16'h0000);
        chk("mis_zero", 0, mis[0], 16'hFE51);
        chk("fc_zero", 0, fc[0], 10);
        chk("ff_zero", 0, ff[0], 0);
        chk("pass_zero", 0, pass[0], 0);
        wait_idle();

        go(2, '0, c0);
        wait_done(0, at);
        chk("table_v8", 0, tab[0], 16'hFF51);
        chk("mis_v8", 0, mis[0], 16'h0100);
        chk("fc_v8", 0, fc[0], 1);
        chk("ff_v8", 0, ff[0], 8);
        chk("pass_v8", 0, pass[0], 0);
        wait_idle();

        n = ndone[0];
        go(0, '0, c0);
        step(19);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("abort_busy", 0, busy[0], 0);
        chk("abort_vec", 0, {a[0], b[0], c[0], d[0]}, 0);
        chk("abort_table", 0, tab[0], 0);
        step(60);
        chk("abort_no_done", 0, ndone[0] - n, 0);
        go(0, '0, c0);
        wait_done(0, at);
        chk("lat_after_abort", 0, at - c0, 48);
        wait_idle();

        n = ndone[0];
        go(0, '0, c0);
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(41);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(0, at);
        chk("lat_extra_start", 0, at - c0, 48);
        step(5);
        chk("one_done", 0, ndone[0] - n, 1);
        wait_idle();

        mode  = 0;
        start = 1'b1;
        step(1);
        c0 = cyc;
        for (int r = 0; r < 3; r++) begin
            wait_done(0, at);
            chk("lat_held", 0, at - c0, 48 + 50 * r);
        end
        start = 1'b0;
        wait_idle();

        go(4, '0, c0);
        wait_done(1, at);
        chk("pass_lag_s1", 1, pass[1], 1);
        chk("table_lag_s1", 1, tab[1], 16'hFE51);
        wait_done(0, at);
        chk("pass_lag_s2", 0, pass[0], 1);
        wait_idle();

        for (int it = 0; it < 8; it++) begin
            go($urandom_range(0, 4), 16'($urandom), c0);
            for (int i = 0; i < 70; i++) begin
                start = $urandom_range(0, 7) == 0;
                rst_n = !(it >= 5 && $urandom_range(0, 49) == 0);
                step(1);
            end
            start = 1'b0;
            rst_n = 1'b1;
            step(1);
            wait_idle();
        end

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
